regfile_arbiter: RTL
====================

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 SHALL have parameter RD_LAT, default 2: cycles from slot start to read data valid on rf_rs1_v/rf_rs2_v (legal 1..4).
REQ-002 SHALL have parameter DBG_STARVE, default 4: max consecutive core grants while d_req is pending (legal 1..15).
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk input 1 (all state on rising edge); rst input 1 (synchronous, active-high).
REQ-004 c_req input 1: core requests an access slot.
REQ-005 c_rs1, c_rs2, c_rd input 5 each: core read and write register indices.
REQ-006 c_rd_v input 32, c_we input 1: core write data and write enable.
REQ-007 c_gnt output 1: core request accepted this cycle.
REQ-008 c_rvalid output 1, c_rs1_v and c_rs2_v output 32 each: core read response.
REQ-009 d_req input 1, d_we input 1, d_addr input 5, d_wdata input 32: debug single-register access.
REQ-010 d_gnt output 1, d_rvalid output 1, d_rdata output 32: debug grant and read response.
REQ-011 rf_rs1, rf_rs2, rf_rd output 5 each, rf_rd_v output 32, rf_we output 1: drive to register file.
REQ-012 rf_rs1_v, rf_rs2_v input 32 each: read data from register file.

Function
REQ-013 SHALL keep a phase bit toggling every cycle; arbitration cycles are phase=0 cycles only.
REQ-014 In an arbitration cycle T, c_gnt/d_gnt SHALL be combinational, at most one high, and high only if the matching req is high; gnt is never high in phase=1 cycles.
REQ-015 Requester fields SHALL be sampled only at the end of its gnt cycle; req and fields need not be held afterwards.
REQ-016 Granted fields SHALL be registered and drive rf_rs1/rf_rs2/rf_rd/rf_rd_v throughout slot cycles S=T+1 and T+2; back-to-back slots SHALL be possible (one per 2 cycles).
REQ-017 Priority: core wins by default; debug wins if c_req=0, or if the starve counter equals DBG_STARVE.
REQ-018 Starve counter SHALL increment on each core grant while d_req=1, saturate at DBG_STARVE, and clear on a debug grant or any arbitration cycle with d_req=0.
REQ-019 Debug read slot: rf_rs1=d_addr, rf_rs2=0, rf_we=0; debug write slot: rf_rd=d_addr, rf_rd_v=d_wdata, rf_rs1=rf_rs2=0.
REQ-020 Core slot: rf_rs1=c_rs1, rf_rs2=c_rs2, rf_rd=c_rd, rf_rd_v=c_rd_v.
REQ-021 rf_we SHALL be high only in cycle S, only for a write slot, and never when the write index is 0 (x0 write silently dropped).
REQ-022 Idle slot (no grant): all rf_* outputs 0.
REQ-023 A tag pipeline of depth RD_LAT SHALL carry {valid, owner} per slot; response SHALL be a one-cycle pulse in cycle S+RD_LAT.
REQ-024 Core slot response: c_rvalid=1, c_rs1_v/c_rs2_v = rf_rs1_v/rf_rs2_v registered at the edge starting S+RD_LAT; every core grant SHALL produce exactly one c_rvalid.
REQ-025 Debug read response: d_rvalid=1, d_rdata=rf_rs1_v captured the same way; debug writes produce no d_rvalid.
REQ-026 Response data outputs SHALL hold their last value when rvalid=0.
REQ-027 Responses SHALL return in grant order, with no loss even when RD_LAT exceeds the 2-cycle slot spacing.

Reset
REQ-028 rst=1 at a rising edge SHALL clear phase to 0, starve counter to 0, all tag valids, all rf_* outputs, c_rvalid, d_rvalid, c_rs1_v, c_rs2_v and d_rdata to 0.
REQ-029 Reset mid-operation SHALL discard in-flight slots: no rvalid and no rf_we after reset for pre-reset grants.
REQ-030 The first cycle with rst=0 SHALL be an arbitration cycle; gnt SHALL be 0 while rst=1.

Verification
REQ-031 Core read: c_req=1, c_rs1=3, c_rs2=5, c_we=0 at T; rf returns 0x11/0x22 -> c_gnt at T, rf_rs1=3 and rf_rs2=5 for T+1..T+2, c_rvalid at T+3 with 0x11/0x22.
REQ-032 x0 write: core c_we=1, c_rd=0, c_rd_v=0xDEADBEEF -> rf_we stays 0, c_rvalid still pulses once.
REQ-033 Starvation: c_req and d_req held high -> 4 core grants, then a debug grant, then the core resumes; grants only on even cycles after reset.
REQ-034 Debug write then read: d_we=1, d_addr=7, d_wdata=0xA5A5A5A5 -> rf_we=1 for exactly one cycle with rf_rd=7; the following debug read has rf_rs1=7, and d_rvalid fires once.
REQ-035 Back-to-back with RD_LAT=4: 3 core grants in consecutive arbitration cycles -> 3 c_rvalid pulses 2 cycles apart, in order, with correct data.
REQ-036 Reset mid-flight: rst=1 one cycle after a grant -> no c_rvalid ever for that grant; all outputs 0 the cycle after reset.

Source files
------------

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-cycle slot arbiter sharing a register file between core and debug, with a debug starvation guard
module regfile_arbiter #(
    parameter int RD_LAT     = 2,
    parameter int DBG_STARVE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic [4:0]  c_rs1,
    input  logic [4:0]  c_rs2,
    input  logic [4:0]  c_rd,
    input  logic [31:0] c_rd_v,
    input  logic        c_we,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rs1_v,
    output logic [31:0] c_rs2_v,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [4:0]  d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [4:0]  rf_rs1,
    output logic [4:0]  rf_rs2,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_rd_v,
    output logic        rf_we,
    input  logic [31:0] rf_rs1_v,
    input  logic [31:0] rf_rs2_v
);
    logic              phase, slot_we, d_win, c_resp, d_resp;
    logic [3:0]        starve;
    logic [RD_LAT-1:0] tag_v, tag_d;
    always_comb begin
        d_win  = d_req && (!c_req || starve == 4'(DBG_STARVE));
        c_gnt  = !rst && !phase && c_req && !d_win;
        d_gnt  = !rst && !phase && d_win;
        rf_we  = phase && slot_we;
        c_resp = tag_v[RD_LAT-1] && !tag_d[RD_LAT-1];
        d_resp = tag_v[RD_LAT-1] && tag_d[RD_LAT-1];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= 1'b0;
            starve   <= 4'd0;
            tag_v    <= '0;
            tag_d    <= '0;
            slot_we  <= 1'b0;
            rf_rs1   <= 5'd0;
            rf_rs2   <= 5'd0;
            rf_rd    <= 5'd0;
            rf_rd_v  <= 32'd0;
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            c_rs1_v  <= 32'd0;
            c_rs2_v  <= 32'd0;
            d_rdata  <= 32'd0;
        end else begin
            phase    <= !phase;
            tag_v    <= RD_LAT'({tag_v, c_gnt || (d_gnt && !d_we)});
            tag_d    <= RD_LAT'({tag_d, d_gnt});
            c_rvalid <= c_resp;
            d_rvalid <= d_resp;
            if (c_resp) begin
                c_rs1_v <= rf_rs1_v;
                c_rs2_v <= rf_rs2_v;
            end
            if (d_resp) d_rdata <= rf_rs1_v;
            if (!phase) begin
                starve  <= (d_gnt || !d_req) ? 4'd0 : starve + 4'd1;
                rf_rs1  <= c_gnt ? c_rs1 : (d_gnt && !d_we) ? d_addr : 5'd0;
                rf_rs2  <= c_gnt ? c_rs2 : 5'd0;
                rf_rd   <= c_gnt ? c_rd : (d_gnt && d_we) ? d_addr : 5'd0;
                rf_rd_v <= c_gnt ? c_rd_v : (d_gnt && d_we) ? d_wdata : 32'd0;
                slot_we <= c_gnt ? (c_we && c_rd != 5'd0) : (d_gnt && d_we && d_addr != 5'd0);
            end
        end
    end
endmodule
